// File: rtl/resource_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : resource_rr_arbiter_pkg
// Description : Shared definitions for the resource round-robin arbiter:
//               default sizing, a constant clog2 helper and the FSM encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package resource_rr_arbiter_pkg;

    // Default sizing used when the arbiter is instantiated without overrides
    localparam int c_def_num_req  = 4;
    localparam int c_def_max_hold = 8;

    // Ceiling log2 for elaboration-time width calculations (bounded loop)
    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

    // Arbiter ownership state
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } arb_state_t;

endpackage : resource_rr_arbiter_pkg
`default_nettype wire

// File: rtl/resource_rr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational rotating priority encoder. Scans req starting at
//               ptr and wrapping modulo NUM_REQ; returns the first set index.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               found,
    output logic [ID_W-1:0]    idx
);

    logic [2*NUM_REQ-1:0] w_dbl;
    logic [2*NUM_REQ-1:0] w_shifted;
    logic [NUM_REQ-1:0]   w_rot;

    // Duplicate the request vector so a plain right shift performs the rotation
    assign w_dbl     = {req, req};
    assign w_shifted = w_dbl >> ptr;
    assign w_rot     = w_shifted[NUM_REQ-1:0];

    // First set bit of the rotated vector, mapped back to an absolute index
    always_comb begin
        logic [ID_W:0] w_sum;
        found = 1'b0;
        idx   = '0;
        w_sum = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && w_rot[i]) begin
                found = 1'b1;
                w_sum = {1'b0, ptr} + (ID_W+1)'(i);
                if (w_sum >= (ID_W+1)'(NUM_REQ)) begin
                    w_sum = w_sum - (ID_W+1)'(NUM_REQ);
                end
                idx = w_sum[ID_W-1:0];
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/resource_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : resource_rr_arbiter
// Description : Round-robin arbiter for a single-ported shared resource. The
//               grant is held across multi-cycle accesses and is released on
//               request drop, done pulse or after MAX_HOLD cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module resource_rr_arbiter
    import resource_rr_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = c_def_num_req,
    parameter int MAX_HOLD = c_def_max_hold,
    parameter int ID_W     = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] done,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_valid,
    output logic [ID_W-1:0]    grant_id
);

    localparam int               c_cnt_w    = clog2(MAX_HOLD);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(MAX_HOLD - 1);
    localparam logic [ID_W-1:0]  c_last_id  = ID_W'(NUM_REQ - 1);

    arb_state_t           r_state, w_state;
    logic [ID_W-1:0]      r_own, w_own;
    logic [c_cnt_w-1:0]   r_cnt, w_cnt;
    logic [ID_W-1:0]      r_ptr, w_ptr;
    logic [NUM_REQ-1:0]   r_grant, w_grant;
    logic                 r_grant_valid, w_grant_valid;
    logic [ID_W-1:0]      r_grant_id, w_grant_id;

    logic                 w_release;
    logic [ID_W-1:0]      w_after_own;
    logic [ID_W-1:0]      w_pick_ptr;
    logic                 w_found;
    logic [ID_W-1:0]      w_idx;

    // Owner gives up the resource on request drop, done, or hold limit reached
    assign w_release = (r_state == ST_OWN) &&
                       (!req[r_own] || done[r_own] || (r_cnt == c_cnt_last));

    // Index just past the owner; the owner becomes lowest priority on release
    assign w_after_own = (r_own == c_last_id) ? '0 : (r_own + ID_W'(1));

    // One encoder serves both the idle pick and the release handoff
    assign w_pick_ptr = (r_state == ST_OWN) ? w_after_own : r_ptr;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req   (req),
        .ptr   (w_pick_ptr),
        .found (w_found),
        .idx   (w_idx)
    );

    // Next-state, pointer, counter and registered-output computation
    always_comb begin
        w_state       = r_state;
        w_own         = r_own;
        w_cnt         = r_cnt;
        w_ptr         = r_ptr;
        w_grant       = '0;
        w_grant_valid = 1'b0;
        w_grant_id    = '0;

        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state = ST_OWN;
                    w_own   = w_idx;
                    w_cnt   = '0;
                end
            end
            ST_OWN: begin
                if (w_release) begin
                    w_ptr = w_after_own;
                    w_cnt = '0;
                    if (w_found) begin
                        w_own = w_idx;
                    end else begin
                        w_state = ST_IDLE;
                    end
                end else begin
                    w_cnt = r_cnt + c_cnt_w'(1);
                end
            end
            default: begin
                w_state = ST_IDLE;
                w_cnt   = '0;
            end
        endcase

        if (w_state == ST_OWN) begin
            w_grant[w_own] = 1'b1;
            w_grant_valid  = 1'b1;
            w_grant_id     = w_own;
        end
    end

    // State and output registers, all cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_own         <= '0;
            r_cnt         <= '0;
            r_ptr         <= '0;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_grant_id    <= '0;
        end else begin
            r_state       <= w_state;
            r_own         <= w_own;
            r_cnt         <= w_cnt;
            r_ptr         <= w_ptr;
            r_grant       <= w_grant;
            r_grant_valid <= w_grant_valid;
            r_grant_id    <= w_grant_id;
        end
    end

    assign grant       = r_grant;
    assign grant_valid = r_grant_valid;
    assign grant_id    = r_grant_id;

endmodule : resource_rr_arbiter
`default_nettype wire

// File: doc/resource_rr_arbiter.md
# resource_rr_arbiter

- Round-robin arbiter that shares one single-ported flop-based resource (register bank, scratch buffer) among `NUM_REQ` requesters.
- Holds a grant across multi-cycle accesses and enforces a bounded hold time to prevent starvation.
- Sits between the issue or fetch requesters and the shared resource.
- All state (grant, owner, pointer, hold counter) is in synchronous-reset flops.

## Interface

Parameters:
- `NUM_REQ`, 4: number of requesters, 2..16.
- `MAX_HOLD`, 8: maximum consecutive cycles one owner keeps the grant, 2..256.
- `ID_W`, 2: width of `grant_id`; must equal clog2(`NUM_REQ`).

Ports:
- `clk`  in  1: single clock; all flops are posedge.
- `rst`  in  1: synchronous, active-high reset.
- `req`  in  NUM_REQ: level request per requester.
- `done`  in  NUM_REQ: owner pulses to end its access; ignored for non-owners.
- `grant`  out  NUM_REQ: registered one-hot grant, or all zero.
- `grant_valid`  out  1: OR of `grant`, registered.
- `grant_id`  out  ID_W: index of the set `grant` bit; 0 when `grant_valid`=0.

## Operation

States:
- **IDLE**: no owner.
- **OWN**: owner index `own`, hold counter `cnt`.

Rotating pointer `ptr` (ID_W bits) gives the highest-priority index. Winner selection: the first index `k` with `req[k]`=1, scanning `ptr`, `ptr+1`, … modulo `NUM_REQ`.

- **IDLE, any `req`**: latch winner into `own`; `cnt`←0; go to OWN; `grant`←onehot(winner).
- **IDLE, no `req`**: stay in IDLE; outputs stay 0.
- **OWN, release condition**: `req[own]`=0, or `done[own]`=1, or `cnt`==`MAX_HOLD`-1.
  - `ptr`←`own`+1 modulo `NUM_REQ`.
  - Winner is selected from the current `req` using the new `ptr`.
  - If a winner exists: grant moves to it the next cycle (no bubble) and `cnt`←0.
  - Otherwise: go to IDLE and `grant`←0.
  - If the owner still requests, it competes at the lowest priority. As sole requester it is regranted and `cnt` restarts at 0.
- **OWN, no release**: `cnt`←`cnt`+1. `cnt` never exceeds `MAX_HOLD`-1 (width clog2(`MAX_HOLD`), no wrap).
- `ptr` changes only on release, never on the initial grant from IDLE.
- `done` on a non-owner, or `done` in IDLE: no effect.
- Requests arriving during OWN wait; they do not preempt.

Reset values: `grant`=0, `grant_valid`=0, `grant_id`=0, state IDLE, `ptr`=0, `cnt`=0.

## Timing

- Request-to-grant latency is 1 cycle: `req` sampled at edge N gives `grant` visible after edge N+1.
- Release evaluation uses `req`/`done` sampled at an edge. The new `grant`, or 0, appears after that same edge, so the handoff takes one cycle with no idle cycle.
- All outputs come straight from flops; there is no combinational path from `req`/`done` to outputs.
- A single-cycle access (`req` high for one cycle) yields `grant` for exactly one cycle. In the cycle after that, the dropped `req` is seen and the grant is released.
- Time-out: an owner with `req` held and no `done` keeps `grant` for exactly `MAX_HOLD` cycles. It is then released even if no other requester exists, and is regranted immediately.
- Reset mid-OWN: on the `rst` edge all outputs go to 0 and `ptr`=0, regardless of `req`/`done`. `rst` overrides every other condition.
- Simultaneous `done[own]` and time-out: treated as one release; `ptr` advances once.

## Structure

- Shared include file `arbiter_defs` holds the default `NUM_REQ`/`MAX_HOLD` values and a clog2 function or macro.
- One sub-module, `rr_pick`: combinational rotating priority encoder (`req`, `ptr` → `found`, `idx`). It is reused by the top for both the IDLE and release selection.
- All sequential state lives in the top module; each flop has synchronous active-high reset.

## Test plan

Defaults used: `NUM_REQ`=4, `MAX_HOLD`=8.

1. **Reset / idle**: hold `rst` for 2 cycles with `req`=4'b1111.
   - `grant`=0 during reset.
   - First cycle after deassert: `grant`=0001, `grant_id`=0.
2. **Rotation**: `req`=1111 held, each owner pulses `done` 2 cycles after its grant.
   - Grant order 0,1,2,3,0, each owner holding 3 cycles.
   - No gap cycles between grants.
3. **Time-out**: `req`=0011 held, no `done`.
   - Requester 0 is granted for exactly 8 cycles, then requester 1 for 8, then 0 again.
4. **Sole requester time-out**: `req`=0100 held.
   - `grant`=0100 continuously.
   - `cnt` returns to 0 every 8 cycles.
   - `ptr` becomes 3 after the first time-out.
5. **Drop / no bubble**: grant to 2, then `req`=1001 while `req[2]` drops.
   - Next cycle `grant`=1000 (ptr=3).
   - Then `req`=0 gives `grant`=0 the cycle after.
6. **Reset mid-OWN and stray `done`**:
   - `done[3]` while 1 owns: no change.
   - Assert `rst` while 1 owns with `req`=0010: `grant`=0 next cycle.
   - After deassert, 1 is regranted with `ptr`=0.
